tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
- IEEE 1149.1 TAP controller: the 16-state TMS-driven FSM that sequences the instruction register and data-register scans.
- Owns the IR shift stage and the IR update latch. `ir_out` drives the instruction decoder.
- Generates capture/shift/update strobes for the externally muxed data registers and retimes TDO.
- Sits between the chip-level JTAG pins and the decoder/DR chain.

Parameters:
- IR_WIDTH, 6, instruction register width.
- IR_RESET_VALUE, 6'b001000, value loaded into `ir_out` in Test-Logic-Reset (IDCODE).
- IR_CAPTURE, 6'b000001, pattern loaded in Capture-IR. The two LSBs must be 2'b01.

Ports:
- tck  in  1  test clock.
- trst  in  1  asynchronous, active-low reset.
- tms  in  1  mode select, sampled on the rising edge of tck.
- tdi  in  1  serial data in.
- dr_tdo  in  1  serial out of the currently selected data register.
- tdo  out  1  serial data out, changes on the falling edge of tck.
- tdo_en  out  1  high while tdo is driving valid data.
- ir_out  out  IR_WIDTH  current instruction, to the instruction decoder.
- tap_state  out  4  current FSM state, for debug/test.
- test_logic_reset  out  1  high while in Test-Logic-Reset.
- run_test_idle  out  1  high while in Run-Test/Idle.
- capture_dr  out  1  high while in Capture-DR.
- shift_dr  out  1  high while in Shift-DR.
- update_dr  out  1  high while in Update-DR.

Behaviour:
- Single clock tck with one asynchronous, active-low reset trst.
  - FSM and IR shift stage update on the rising edge.
  - ir_out, tdo and tdo_en update on the falling edge.
- Reset values (trst low): state=Test-Logic-Reset, ir shift stage=IR_CAPTURE, ir_out=IR_RESET_VALUE, tdo=0, tdo_en=0.
  - Decoded strobes follow from state: test_logic_reset=1, all others 0.
  - Reset applies immediately, including mid-scan. A partial shift is discarded and ir_out is not updated from it.
- State encoding (4-bit): Exit2-DR 0, Exit1-DR 1, Shift-DR 2, Pause-DR 3, Select-IR-Scan 4, Update-DR 5, Capture-DR 6, Select-DR-Scan 7, Exit2-IR 8, Exit1-IR 9, Shift-IR A, Pause-IR B, Run-Test/Idle C, Update-IR D, Capture-IR E, Test-Logic-Reset F.
- Transitions, given as current: next on tms=0 / next on tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapXR: ShiftXR / Exit1XR
  - ShiftXR: ShiftXR / Exit1XR
  - Exit1XR: PauseXR / UpdXR
  - PauseXR: PauseXR / Exit2XR
  - Exit2XR: ShiftXR / UpdXR
  - UpdXR: RTI / SelDR
- Five consecutive tms=1 rising edges reach TLR from any state.
- Strobes are combinational decodes of the current state, with one-cycle latency from tms.
  - DRs act on the rising edge that ends Capture-DR and each Shift-DR cycle.
  - DRs act on the falling edge within Update-DR.
- IR shift stage (rising edge):
  - In Capture-IR, loads IR_CAPTURE.
  - In Shift-IR, loads {tdi, ir_shift[IR_WIDTH-1:1]}, LSB first out.
  - Holds in Pause-IR and Exit states.
- ir_out (falling edge):
  - In Update-IR, loads the shift stage.
  - In TLR, loads IR_RESET_VALUE.
  - Otherwise holds. It never changes during Capture/Shift/Pause.
- tdo / tdo_en (falling edge):
  - In Shift-IR: tdo=ir_shift[0], tdo_en=1.
  - In Shift-DR: tdo=dr_tdo, tdo_en=1.
  - Otherwise tdo_en=0 and tdo holds its last value.
- Boundary cases:
  - Shift-IR for more than IR_WIDTH cycles: older bits fall off; ir_out receives the last IR_WIDTH tdi bits.
  - Zero shift cycles (Capture→Exit1→Update): ir_out=IR_CAPTURE.
  - Pause/Exit2 re-entry into Shift continues the shift without recapture.

Decomposition:
- Package `jtag_pkg`: `tap_state_t` enum with the encoding above.
- Sub-module `tap_fsm`: state register plus next-state logic, exposing tap_state. It is natural as the only reusable piece.
- IR stage, update latch and TDO retiming stay in `tap_controller`.

Test Plan:
- Reset and TLR recovery:
  - trst low mid-Shift-IR → tap_state=F, ir_out=6'b001000, tdo_en=0 immediately.
  - From each of the 16 states, 5×tms=1 → state F.
- IR scan: from RTI, tms 1,1,0,0 then shift tdi 0,0,1,0,0,0 (last bit with tms=1), then tms 1,0.
  - tdo shows 1,0,0,0,0,0 (IR_CAPTURE, LSB first).
  - ir_out=6'b000100 on the falling edge in Update-IR, unchanged before.
- DR path: tms 1,0,0, hold dr_tdo=1 for 4 shift cycles.
  - capture_dr high for exactly 1 cycle, then shift_dr high 4 cycles, then update_dr 1 cycle.
  - tdo=1 with tdo_en=1 only during Shift-DR falling edges.
- Pause/resume: shift 3 IR bits (1,1,1), Exit1→Pause (hold 5 cycles)→Exit2→Shift, shift 3 bits (1,0,1), update.
  - ir_out=6'b101111, i.e. no recapture.
- Zero-length IR scan: Capture-IR→Exit1-IR→Update-IR → ir_out=6'b000001.
- Walk all transitions with random tms for 10k cycles against a reference model → tap_state and strobes match every cycle.

Source files
------------

// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared types for the JTAG TAP block.
//   tap_state_t : 4-bit encoding of the 16 IEEE 1149.1 TAP states. The
//                 encoding is visible on the tap_state debug port, so it is
//                 fixed rather than left to the synthesis tool.
//   tap_is_shift: true in either shift state (the cycles in which TDO is driven)
// -----------------------------------------------------------------------------
package jtag_pkg;

   localparam int TAP_STATE_W = 4;

   typedef enum logic [TAP_STATE_W-1:0] {
      EXIT2_DR   = 4'h0,
      EXIT1_DR   = 4'h1,
      SHIFT_DR   = 4'h2,
      PAUSE_DR   = 4'h3,
      SELECT_IR  = 4'h4,
      UPDATE_DR  = 4'h5,
      CAPTURE_DR = 4'h6,
      SELECT_DR  = 4'h7,
      EXIT2_IR   = 4'h8,
      EXIT1_IR   = 4'h9,
      SHIFT_IR   = 4'hA,
      PAUSE_IR   = 4'hB,
      RUN_IDLE   = 4'hC,
      UPDATE_IR  = 4'hD,
      CAPTURE_IR = 4'hE,
      TEST_RESET = 4'hF
   } tap_state_t;

   function automatic logic tap_is_shift(input tap_state_t s);
      return (s == SHIFT_IR) || (s == SHIFT_DR);
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// -----------------------------------------------------------------------------
// tap_fsm
// The 16-state TMS-driven TAP state machine. State advances on the rising
// edge of the test clock; an asynchronous active-low reset forces
// Test-Logic-Reset immediately.
//
// Ports
//   i_tck    : test clock
//   i_trst_n : asynchronous reset, active low
//   i_tms    : mode select, sampled on the rising edge
//   o_state  : current state
//
// state      | meaning
// -----------+-------------------------------------------------------------
// TEST_RESET | test logic idle and reset; IR forced to its reset value
// RUN_IDLE   | idle between scans
// SELECT_DR  | choose between DR scan (tms=0) and IR path (tms=1)
// CAPTURE_DR | selected DR loads its parallel input
// SHIFT_DR   | selected DR shifts one bit per cycle tdi -> tdo
// EXIT1_DR   | leave shift; go to pause (tms=0) or update (tms=1)
// PAUSE_DR   | DR shift suspended, contents held
// EXIT2_DR   | resume shift (tms=0) or update (tms=1)
// UPDATE_DR  | selected DR latches its shifted value
// SELECT_IR  | choose between IR scan (tms=0) and reset (tms=1)
// CAPTURE_IR | IR shift stage loads the capture pattern
// SHIFT_IR   | IR shift stage shifts one bit per cycle tdi -> tdo
// EXIT1_IR   | leave shift; go to pause (tms=0) or update (tms=1)
// PAUSE_IR   | IR shift suspended, contents held
// EXIT2_IR   | resume shift (tms=0) or update (tms=1)
// UPDATE_IR  | instruction output loads the IR shift stage
// -----------------------------------------------------------------------------
module tap_fsm
   import jtag_pkg::*;
(
   input  logic       i_tck,
   input  logic       i_trst_n,
   input  logic       i_tms,
   output tap_state_t o_state
);

   tap_state_t r_state;
   tap_state_t w_next;

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) r_state <= TEST_RESET;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         TEST_RESET: w_next = i_tms ? TEST_RESET : RUN_IDLE;
         RUN_IDLE:   w_next = i_tms ? SELECT_DR  : RUN_IDLE;
         SELECT_DR:  w_next = i_tms ? SELECT_IR  : CAPTURE_DR;
         SELECT_IR:  w_next = i_tms ? TEST_RESET : CAPTURE_IR;
         CAPTURE_DR: w_next = i_tms ? EXIT1_DR   : SHIFT_DR;
         SHIFT_DR:   w_next = i_tms ? EXIT1_DR   : SHIFT_DR;
         EXIT1_DR:   w_next = i_tms ? UPDATE_DR  : PAUSE_DR;
         PAUSE_DR:   w_next = i_tms ? EXIT2_DR   : PAUSE_DR;
         EXIT2_DR:   w_next = i_tms ? UPDATE_DR  : SHIFT_DR;
         UPDATE_DR:  w_next = i_tms ? SELECT_DR  : RUN_IDLE;
         CAPTURE_IR: w_next = i_tms ? EXIT1_IR   : SHIFT_IR;
         SHIFT_IR:   w_next = i_tms ? EXIT1_IR   : SHIFT_IR;
         EXIT1_IR:   w_next = i_tms ? UPDATE_IR  : PAUSE_IR;
         PAUSE_IR:   w_next = i_tms ? EXIT2_IR   : PAUSE_IR;
         EXIT2_IR:   w_next = i_tms ? UPDATE_IR  : SHIFT_IR;
         UPDATE_IR:  w_next = i_tms ? SELECT_DR  : RUN_IDLE;
         default:    w_next = TEST_RESET;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
// IEEE 1149.1 TAP controller: state machine, IR shift stage and update latch,
// DR capture/shift/update strobes, and falling-edge TDO retiming.
//
// Ports
//   tck              : test clock
//   trst             : asynchronous reset, active low
//   tms              : mode select, sampled on rising tck
//   tdi              : serial data in
//   dr_tdo           : serial out of the currently selected data register
//   tdo              : serial data out, changes on falling tck
//   tdo_en           : tdo carries valid shift data
//   ir_out           : current instruction, to the instruction decoder
//   tap_state        : current TAP state (debug)
//   test_logic_reset : in Test-Logic-Reset
//   run_test_idle    : in Run-Test/Idle
//   capture_dr       : in Capture-DR
//   shift_dr         : in Shift-DR
//   update_dr        : in Update-DR
//
// IR_CAPTURE must have 2'b01 in its two LSBs.
// -----------------------------------------------------------------------------
module tap_controller
   import jtag_pkg::*;
#(
   parameter int                  IR_WIDTH       = 6,
   parameter logic [IR_WIDTH-1:0] IR_RESET_VALUE = 6'b001000,
   parameter logic [IR_WIDTH-1:0] IR_CAPTURE     = 6'b000001
) (
   input  logic                tck,
   input  logic                trst,
   input  logic                tms,
   input  logic                tdi,
   input  logic                dr_tdo,
   output logic                tdo,
   output logic                tdo_en,
   output logic [IR_WIDTH-1:0] ir_out,
   output logic [3:0]          tap_state,
   output logic                test_logic_reset,
   output logic                run_test_idle,
   output logic                capture_dr,
   output logic                shift_dr,
   output logic                update_dr
);

   tap_state_t          w_state;
   logic [IR_WIDTH-1:0] r_ir_shift;
   logic [IR_WIDTH-1:0] r_ir_out;
   logic                r_tdo;
   logic                r_tdo_en;

   tap_fsm u_fsm (
      .i_tck    (tck),
      .i_trst_n (trst),
      .i_tms    (tms),
      .o_state  (w_state)
   );

   // IR shift stage: rising edge, LSB leaves first toward tdo.
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         r_ir_shift <= IR_CAPTURE;
      end else begin
         case (w_state)
            CAPTURE_IR: r_ir_shift <= IR_CAPTURE;
            SHIFT_IR:   r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
            default:    r_ir_shift <= r_ir_shift;
         endcase
      end
   end

   // Falling-edge side: the instruction only changes mid-cycle in Update-IR
   // or Test-Logic-Reset, so the decoder never sees a partially shifted value.
   always_ff @(negedge tck or negedge trst) begin
      if (!trst) begin
         r_ir_out <= IR_RESET_VALUE;
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else begin
         case (w_state)
            UPDATE_IR:  r_ir_out <= r_ir_shift;
            TEST_RESET: r_ir_out <= IR_RESET_VALUE;
            default:    r_ir_out <= r_ir_out;
         endcase

         // tdo keeps its last value outside shift so the pin does not toggle
         // needlessly while tdo_en is low.
         case (w_state)
            SHIFT_IR: r_tdo <= r_ir_shift[0];
            SHIFT_DR: r_tdo <= dr_tdo;
            default:  r_tdo <= r_tdo;
         endcase
         r_tdo_en <= tap_is_shift(w_state);
      end
   end

   assign ir_out           = r_ir_out;
   assign tdo              = r_tdo;
   assign tdo_en           = r_tdo_en;
   assign tap_state        = w_state;
   assign test_logic_reset = (w_state == TEST_RESET);
   assign run_test_idle    = (w_state == RUN_IDLE);
   assign capture_dr       = (w_state == CAPTURE_DR);
   assign shift_dr         = (w_state == SHIFT_DR);
   assign update_dr        = (w_state == UPDATE_DR);

endmodule

// File: tb/tb_tap_controller.sv
module tb_tap_controller;

   localparam logic [3:0] S_E2D = 4'h0, S_E1D = 4'h1, S_SHD = 4'h2, S_PSD = 4'h3,
                          S_SIR = 4'h4, S_UDR = 4'h5, S_CDR = 4'h6, S_SDR = 4'h7,
                          S_E2I = 4'h8, S_E1I = 4'h9, S_SHI = 4'hA, S_PSI = 4'hB,
                          S_RTI = 4'hC, S_UIR = 4'hD, S_CIR = 4'hE, S_TLR = 4'hF;

   logic       tck = 1'b0;
   logic       trst = 1'b0;
   logic       tms = 1'b1;
   logic       tdi = 1'b0;
   logic       dr_tdo = 1'b0;
   logic       tdo, tdo_en;
   logic [5:0] ir_out;
   logic [3:0] tap_state;
   logic       test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr;

   tap_controller dut (
      .tck              (tck),
      .trst             (trst),
      .tms              (tms),
      .tdi              (tdi),
      .dr_tdo           (dr_tdo),
      .tdo              (tdo),
      .tdo_en           (tdo_en),
      .ir_out           (ir_out),
      .tap_state        (tap_state),
      .test_logic_reset (test_logic_reset),
      .run_test_idle    (run_test_idle),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr)
   );

   always #5 tck = ~tck;

   typedef struct {
      string      nm;
      logic [3:0] st;
      logic [4:0] stb;
      logic       en;
      logic       chk_ir;
      logic [5:0] ir;
      logic       chk_tdo;
      logic       tdo;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] m_st;
   logic [5:0] exp_ir;
   logic       chk_ir_on;

   function automatic logic [3:0] nxt(input logic [3:0] s, input logic t);
      case (s)
         S_TLR:        return t ? S_TLR : S_RTI;
         S_RTI:        return t ? S_SDR : S_RTI;
         S_SDR:        return t ? S_SIR : S_CDR;
         S_SIR:        return t ? S_TLR : S_CIR;
         S_CDR, S_SHD: return t ? S_E1D : S_SHD;
         S_E1D:        return t ? S_UDR : S_PSD;
         S_PSD:        return t ? S_E2D : S_PSD;
         S_E2D:        return t ? S_UDR : S_SHD;
         S_UDR, S_UIR: return t ? S_SDR : S_RTI;
         S_CIR, S_SHI: return t ? S_E1I : S_SHI;
         S_E1I:        return t ? S_UIR : S_PSI;
         S_PSI:        return t ? S_E2I : S_PSI;
         S_E2I:        return t ? S_UIR : S_SHI;
         default:      return S_TLR;
      endcase
   endfunction

   function automatic logic [4:0] stb(input logic [3:0] s);
      return {s == S_TLR, s == S_RTI, s == S_CDR, s == S_SHD, s == S_UDR};
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: one expectation per clock, sampled after the falling edge.
   initial begin
      forever begin
         @(negedge tck);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.nm, " state"}, 32'(tap_state), 32'(e.st));
            cmp({e.nm, " strobes"},
                32'({test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr}),
                32'(e.stb));
            cmp({e.nm, " tdo_en"}, 32'(tdo_en), 32'(e.en));
            if (e.chk_ir)  cmp({e.nm, " ir_out"}, 32'(ir_out), 32'(e.ir));
            if (e.chk_tdo) cmp({e.nm, " tdo"}, 32'(tdo), 32'(e.tdo));
         end
      end
   end

   // Called at negedge+2; drives one tms/tdi pair and queues the expected
   // response for the cycle that follows.
   task automatic step(input logic t, input logic d, input string nm,
                       input logic ct = 1'b0, input logic et = 1'b0);
      exp_t e;
      tms  = t;
      tdi  = d;
      m_st = nxt(m_st, t);
      e.nm      = nm;
      e.st      = m_st;
      e.stb     = stb(m_st);
      e.en      = (m_st == S_SHI) || (m_st == S_SHD);
      e.chk_ir  = chk_ir_on;
      e.ir      = exp_ir;
      e.chk_tdo = ct || (m_st == S_SHD);
      e.tdo     = (m_st == S_SHD) ? dr_tdo : et;
      q.push_back(e);
      @(negedge tck);
      #2;
   endtask

   task automatic seq(input string bits, input string nm);
      for (int i = 0; i < bits.len(); i++)
         step(bits.getc(i) == "1", 1'b0, nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                        "01011", "011", "0110", "01100", "01101", "011010",
                        "0110101", "011011"};

   initial begin
      chk_ir_on = 1'b1;
      exp_ir    = 6'b001000;
      m_st      = S_TLR;
      repeat (2) @(negedge tck);
      #2;
      cmp("rst state", 32'(tap_state), 32'(S_TLR));
      cmp("rst strobes", 32'({test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr}),
          32'(5'b10000));
      cmp("rst ir_out", 32'(ir_out), 32'(6'b001000));
      cmp("rst tdo", 32'(tdo), 32'(0));
      cmp("rst tdo_en", 32'(tdo_en), 32'(0));
      trst = 1'b1;

      // Five tms=1 edges recover from every state.
      chk_ir_on = 1'b0;
      for (int i = 0; i < 16; i++) begin
         seq(paths[i], $sformatf("nav%0d", i));
         seq("11111", $sformatf("tlr5_from%0d", i));
      end
      chk_ir_on = 1'b1;
      exp_ir    = 6'b001000;

      // IR scan: capture pattern out LSB first, 000100 loaded at Update-IR.
      step(0, 0, "ir_rti");
      step(1, 0, "ir_seldr");
      step(1, 0, "ir_selir");
      step(0, 0, "ir_cap");
      step(0, 0, "ir_sh0", 1, 1);
      step(0, 0, "ir_sh1", 1, 0);
      step(0, 0, "ir_sh2", 1, 0);
      step(0, 1, "ir_sh3", 1, 0);
      step(0, 0, "ir_sh4", 1, 0);
      step(0, 0, "ir_sh5", 1, 0);
      step(1, 0, "ir_exit1", 1, 0);
      exp_ir = 6'b000100;
      step(1, 0, "ir_upd");
      step(0, 0, "ir_back_rti");

      // DR path with dr_tdo held high for four shift cycles.
      dr_tdo = 1'b1;
      step(1, 0, "dr_seldr");
      step(0, 0, "dr_cap", 1, 0);
      step(0, 0, "dr_sh0");
      step(0, 0, "dr_sh1");
      step(0, 0, "dr_sh2");
      step(0, 0, "dr_sh3");
      dr_tdo = 1'b0;
      step(1, 0, "dr_exit1_hold", 1, 1);
      step(1, 0, "dr_upd_hold", 1, 1);
      step(0, 0, "dr_rti");

      // Pause/resume: 1,1,1 then pause 5 cycles then 1,0,1 -> 101111.
      step(1, 0, "pr_seldr");
      step(1, 0, "pr_selir");
      step(0, 0, "pr_cap");
      step(0, 0, "pr_shift");
      step(0, 1, "pr_a0");
      step(0, 1, "pr_a1");
      step(1, 1, "pr_a2");
      step(0, 1, "pr_pause");
      for (int i = 0; i < 4; i++) step(0, 1, "pr_pause_hold");
      step(1, 0, "pr_exit2");
      step(0, 0, "pr_reshift");
      step(0, 1, "pr_b0");
      step(0, 0, "pr_b1");
      step(1, 1, "pr_b2");
      exp_ir = 6'b101111;
      step(1, 0, "pr_upd");
      step(0, 0, "pr_rti");

      // Zero-length IR scan loads the capture pattern.
      step(1, 0, "z_seldr");
      step(1, 0, "z_selir");
      step(0, 0, "z_cap");
      step(1, 0, "z_exit1");
      exp_ir = 6'b000001;
      step(1, 0, "z_upd");
      step(0, 0, "z_rti");

      // Reset in the middle of an IR shift.
      step(1, 0, "mr_seldr");
      step(1, 0, "mr_selir");
      step(0, 0, "mr_cap");
      step(0, 0, "mr_shift", 1, 1);
      step(0, 1, "mr_shift1", 1, 0);
      trst = 1'b0;
      #1;
      cmp("midrst state", 32'(tap_state), 32'(S_TLR));
      cmp("midrst ir_out", 32'(ir_out), 32'(6'b001000));
      cmp("midrst tdo_en", 32'(tdo_en), 32'(0));
      cmp("midrst tlr", 32'(test_logic_reset), 32'(1));
      @(negedge tck);
      #2;
      trst   = 1'b1;
      m_st   = S_TLR;
      exp_ir = 6'b001000;
      step(1, 0, "post_rst_tlr");

      // Random walk against the transition table.
      chk_ir_on = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         dr_tdo = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
      end

      repeat (3) @(negedge tck);
      cmp("queue drained", 32'(q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
